// File: rtl/alu_sequencer.sv
// Sweeps one latched operand set through every ALU opcode and stores each 9-bit result.
// Latency: NUM_OPS*(2+SETTLE) cycles from the accepted start edge to the done pulse.
// Backpressure: none; start is only sampled in IDLE and is ignored while a sweep runs.
module alu_sequencer #(
    parameter int NUM_OPS = 8,
    parameter int SETTLE  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    input  logic       ci_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_ci,
    output logic [2:0] alu_s,
    input  logic [8:0] alu_o,
    input  logic [2:0] rd_addr,
    output logic [8:0] rd_data,
    output logic [8:0] xor_sig
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRIVE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    localparam logic [2:0] LAST_OP   = 3'(NUM_OPS - 1);
    // The wait counter is loaded with SETTLE-1 and leaves WAIT when it reaches zero.
    localparam logic [3:0] WAIT_INIT = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    state_t     state_q, state_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    // The ALU operand registers double as the latched copy of the start operands.
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic       alu_ci_q, alu_ci_d;
    logic [2:0] op_q, op_d;
    logic [3:0] cnt_q, cnt_d;
    logic [8:0] xor_sig_q, xor_sig_d;
    logic [8:0] bank_q [NUM_OPS];
    logic [8:0] bank_d [NUM_OPS];

    // Next-state and next-output computation for the sweep controller.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_ci_d  = alu_ci_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        xor_sig_d = xor_sig_q;
        for (int i = 0; i < NUM_OPS; i++) begin
            bank_d[i] = bank_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    alu_a_d   = a_in;
                    alu_b_d   = b_in;
                    alu_ci_d  = ci_in;
                    op_d      = 3'd0;
                    xor_sig_d = 9'd0;
                    busy_d    = 1'b1;
                    state_d   = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (SETTLE > 0) begin
                    cnt_d   = WAIT_INIT;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_CAPTURE: begin
                for (int i = 0; i < NUM_OPS; i++) begin
                    if (op_q == 3'(i)) begin
                        bank_d[i] = alu_o;
                    end
                end
                xor_sig_d = xor_sig_q ^ alu_o;
                if (op_q == LAST_OP) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    op_d    = op_q + 3'd1;
                    state_d = S_DRIVE;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, registered outputs and result bank; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            alu_a_q   <= 8'd0;
            alu_b_q   <= 8'd0;
            alu_ci_q  <= 1'b0;
            op_q      <= 3'd0;
            cnt_q     <= 4'd0;
            xor_sig_q <= 9'd0;
            for (int i = 0; i < NUM_OPS; i++) begin
                bank_q[i] <= 9'd0;
            end
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_ci_q  <= alu_ci_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            xor_sig_q <= xor_sig_d;
            for (int i = 0; i < NUM_OPS; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    // Combinational bank read; indices beyond the swept opcodes read as zero.
    always_comb begin
        rd_data = 9'd0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (rd_addr == 3'(i)) begin
                rd_data = bank_q[i];
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_ci  = alu_ci_q;
    assign alu_s   = op_q;
    assign xor_sig = xor_sig_q;

endmodule
